// File: rtl/pztb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pztb_pkg
//  Description : Shared types and constants for the 2-read/1-write memory
//                controller (memory_2r1w_ctrl) and its response FIFO.
//  Contents    : pztb_mem_ctrl_state_e - controller state (INIT sweep / RUN)
//                RSP_DEPTH             - response buffer depth per read port
//  Revision    : 1.0  initial release
// ============================================================================
package pztb_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } pztb_mem_ctrl_state_e;

  localparam int RSP_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/memory_ctrl_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : memory_ctrl_rsp_fifo
//  Description : 2-entry valid/ready FIFO holding read responses for one
//                memory read port. The head word is held stable until popped.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                in_valid/in_ready/in_data    - push side
//                out_valid/out_ready/out_data - pop side
//  Revision    : 1.0  initial release
// ============================================================================
module memory_ctrl_rsp_fifo
  import pztb_pkg::*;
#(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data
);

  logic [DATAW-1:0] mem [RSP_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_2r1w_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : memory_2r1w_ctrl
//  Description : Controller for a 2-read/1-write synchronous memory (read
//                latency 1). After reset it clears every word, then serves
//                one write port (A) and two independent read ports (B, C),
//                each read port with a 2-deep in-order response buffer.
//  Ports       : i_clk, i_rst_n (async active-low), o_init_done
//                write request : i_wr_valid/o_wr_ready/i_wr_addr/data/mask
//                read B / C    : i_r?_valid/o_r?_ready/i_r?_addr,
//                                o_r?_rvalid/i_r?_rready/o_r?_rdata
//                memory side   : o_adra/o_da/o_wema/o_wea/o_mea,
//                                o_adrb/o_meb/i_qb, o_adrc/o_mec/i_qc
//  Config      : PZTB_MEM_CTRL_BYPASS_EN - a read colliding with a same-cycle
//                write is accepted and returns the merged write data;
//                otherwise the colliding read is stalled one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_2r1w_ctrl
  import pztb_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int WORDW = 1024,
  parameter int ADDRW = $clog2(WORDW)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_init_done,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [ADDRW-1:0] i_wr_addr,
  input  logic [DATAW-1:0] i_wr_data,
  input  logic [DATAW-1:0] i_wr_mask,
  input  logic             i_rb_valid,
  output logic             o_rb_ready,
  input  logic [ADDRW-1:0] i_rb_addr,
  output logic             o_rb_rvalid,
  input  logic             i_rb_rready,
  output logic [DATAW-1:0] o_rb_rdata,
  input  logic             i_rc_valid,
  output logic             o_rc_ready,
  input  logic [ADDRW-1:0] i_rc_addr,
  output logic             o_rc_rvalid,
  input  logic             i_rc_rready,
  output logic [DATAW-1:0] o_rc_rdata,
  output logic [ADDRW-1:0] o_adra,
  output logic [DATAW-1:0] o_da,
  output logic [DATAW-1:0] o_wema,
  output logic             o_wea,
  output logic             o_mea,
  output logic [ADDRW-1:0] o_adrb,
  output logic             o_meb,
  output logic [ADDRW-1:0] o_adrc,
  output logic             o_mec,
  input  logic [DATAW-1:0] i_qb,
  input  logic [DATAW-1:0] i_qc
);

  pztb_mem_ctrl_state_e state, state_nxt;
  logic [ADDRW-1:0]     sweep_addr;
  logic                 sweep_armed;   // keeps enables low during reset itself
  logic                 sweep_last;
  logic                 sweep_we;
  logic                 run;
  logic                 wr_fire;

  assign sweep_last  = (sweep_addr == ADDRW'(WORDW - 1));
  assign o_init_done = run;
  assign o_wr_ready  = run;
  assign wr_fire     = i_wr_valid && run;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= INIT;
      sweep_addr  <= '0;
      sweep_armed <= 1'b0;
    end else begin
      state       <= state_nxt;
      sweep_armed <= 1'b1;
      if (sweep_we) sweep_addr <= sweep_addr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_we  = 1'b0;
    run       = 1'b0;
    case (state)
      INIT: begin
        sweep_we = sweep_armed;
        if (sweep_armed && sweep_last) state_nxt = RUN;
      end
      RUN:     run = 1'b1;
      default: state_nxt = INIT;
    endcase
  end

  // Write port: clear sweep during INIT, request writes during RUN.
  always_comb begin
    o_mea  = 1'b0;
    o_wea  = 1'b0;
    o_adra = '0;
    o_da   = '0;
    o_wema = '0;
    if (sweep_we) begin
      o_mea  = 1'b1;
      o_wea  = 1'b1;
      o_adra = sweep_addr;
      o_wema = '1;
    end else if (wr_fire) begin
      o_mea  = 1'b1;
      o_wea  = 1'b1;
      o_adra = i_wr_addr;
      o_da   = i_wr_data;
      o_wema = i_wr_mask;
    end
  end

  // Read ports handled as index 0 = B, 1 = C.
  logic [1:0]       rd_valid, rd_ready, rd_fire, rsp_valid, rsp_ready;
  logic [ADDRW-1:0] rd_addr  [2];
  logic [DATAW-1:0] rd_q     [2];
  logic [DATAW-1:0] rsp_data [2];

  assign rd_valid   = {i_rc_valid, i_rb_valid};
  assign rsp_ready  = {i_rc_rready, i_rb_rready};
  assign rd_addr[0] = i_rb_addr;
  assign rd_addr[1] = i_rc_addr;
  assign rd_q[0]    = i_qb;
  assign rd_q[1]    = i_qc;
  assign rd_fire    = rd_valid & rd_ready;

  assign o_rb_ready  = rd_ready[0];
  assign o_rc_ready  = rd_ready[1];
  assign o_rb_rvalid = rsp_valid[0];
  assign o_rc_rvalid = rsp_valid[1];
  assign o_rb_rdata  = rsp_data[0];
  assign o_rc_rdata  = rsp_data[1];
  assign o_meb       = rd_fire[0];
  assign o_mec       = rd_fire[1];
  assign o_adrb      = rd_fire[0] ? i_rb_addr : '0;
  assign o_adrc      = rd_fire[1] ? i_rc_addr : '0;

`ifdef PZTB_MEM_CTRL_BYPASS_EN
  // Write data/mask of the previous cycle, merged into a colliding read's
  // memory output (the memory itself returns pre-write data).
  logic [DATAW-1:0] byp_data, byp_mask;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byp_data <= '0;
      byp_mask <= '0;
    end else if (wr_fire) begin
      byp_data <= i_wr_data;
      byp_mask <= i_wr_mask;
    end
  end
`endif

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic             inflight;
    logic             collide;
    logic             stall;
    logic             pop;
    logic             fifo_in_ready;
    logic [1:0]       buf_cnt;
    logic [1:0]       occupancy;
    logic [DATAW-1:0] push_data;

    assign collide = i_wr_valid && (rd_addr[p] == i_wr_addr);
    assign pop     = rsp_valid[p] && rsp_ready[p];
    // Buffer fill level recovered from the FIFO handshake flags.
    assign buf_cnt   = !fifo_in_ready ? 2'd2 : {1'b0, rsp_valid[p]};
    assign occupancy = buf_cnt + {1'b0, inflight};
    // A same-cycle pop frees a slot, so a full buffer can still accept.
    assign rd_ready[p] = run && !stall && ((occupancy - {1'b0, pop}) < 2'd2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) inflight <= 1'b0;
      else          inflight <= rd_fire[p];
    end

`ifdef PZTB_MEM_CTRL_BYPASS_EN
    logic byp_hit;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) byp_hit <= 1'b0;
      else          byp_hit <= rd_fire[p] && collide;
    end
    assign stall     = 1'b0;
    assign push_data = byp_hit ? ((byp_data & byp_mask) | (rd_q[p] & ~byp_mask))
                               : rd_q[p];
`else
    assign stall     = collide;
    assign push_data = rd_q[p];
`endif

    memory_ctrl_rsp_fifo #(
      .DATAW (DATAW)
    ) u_rsp_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .in_valid  (inflight),
      .in_ready  (fifo_in_ready),
      .in_data   (push_data),
      .out_valid (rsp_valid[p]),
      .out_ready (rsp_ready[p]),
      .out_data  (rsp_data[p])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_2r1w_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_2r1w_ctrl
//  Description : Self-checking bench for memory_2r1w_ctrl (WORDW=16). A
//                2R1W read-first memory model is attached to the memory-side
//                ports; an architectural reference memory plus per-port
//                response queues predict every read response.
//  Config      : PZTB_MEM_CTRL_BYPASS_EN selects collision expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_2r1w_ctrl;

  localparam int DATAW = 32;
  localparam int WORDW = 16;
  localparam int ADDRW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             init_done;
  logic             wr_valid, wr_ready;
  logic [ADDRW-1:0] wr_addr;
  logic [DATAW-1:0] wr_data, wr_mask;
  logic             rb_valid, rb_ready, rb_rvalid, rb_rready;
  logic [ADDRW-1:0] rb_addr;
  logic [DATAW-1:0] rb_rdata;
  logic             rc_valid, rc_ready, rc_rvalid, rc_rready;
  logic [ADDRW-1:0] rc_addr;
  logic [DATAW-1:0] rc_rdata;
  logic [ADDRW-1:0] adra, adrb, adrc;
  logic [DATAW-1:0] da, wema, qb, qc;
  logic             wea, mea, meb, mec;

  always #5 clk = ~clk;

  memory_2r1w_ctrl #(.DATAW(DATAW), .WORDW(WORDW), .ADDRW(ADDRW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_init_done(init_done),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_mask(wr_mask),
    .i_rb_valid(rb_valid), .o_rb_ready(rb_ready), .i_rb_addr(rb_addr),
    .o_rb_rvalid(rb_rvalid), .i_rb_rready(rb_rready), .o_rb_rdata(rb_rdata),
    .i_rc_valid(rc_valid), .o_rc_ready(rc_ready), .i_rc_addr(rc_addr),
    .o_rc_rvalid(rc_rvalid), .i_rc_rready(rc_rready), .o_rc_rdata(rc_rdata),
    .o_adra(adra), .o_da(da), .o_wema(wema), .o_wea(wea), .o_mea(mea),
    .o_adrb(adrb), .o_meb(meb), .o_adrc(adrc), .o_mec(mec),
    .i_qb(qb), .i_qc(qc)
  );

  // Physical 2R1W memory, read-first, latency 1.
  logic [DATAW-1:0] phys [WORDW];
  always @(posedge clk) begin
    if (meb) qb <= phys[adrb];
    if (mec) qc <= phys[adrc];
    if (mea && wea) phys[adra] <= (phys[adra] & ~wema) | (da & wema);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural memory and expected responses per port.
  logic [DATAW-1:0] refm [WORDW];
  logic [DATAW-1:0] expq [2][$];
  int               fcq  [2][$];
  logic             hold [2];
  logic [DATAW-1:0] held [2];
  int               cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin : mon
    logic [1:0]       v, rdy, rv, rr, me;
    logic [ADDRW-1:0] ad [2];
    logic [ADDRW-1:0] madr [2];
    logic [DATAW-1:0] rd [2];
    logic             run_exp, stall, pop, fire, exp_rdy;
    string            pn;
    v  = {rc_valid, rb_valid};   rdy = {rc_ready, rb_ready};
    rv = {rc_rvalid, rb_rvalid}; rr  = {rc_rready, rb_rready};
    me = {mec, meb};
    ad[0] = rb_addr; ad[1] = rc_addr; madr[0] = adrb; madr[1] = adrc;
    rd[0] = rb_rdata; rd[1] = rc_rdata;
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        expq[p].delete(); fcq[p].delete(); hold[p] = 1'b0;
      end
      for (int i = 0; i < WORDW; i++) refm[i] = '0;
      chk("rst_rvalid", 64'(rv), 64'd0);
      chk("rst_ready", 64'({wr_ready, rdy}), 64'd0);
      chk("rst_enables", 64'({mea, wea, me}), 64'd0);
      chk("rst_done", 64'(init_done), 64'd0);
      chk("rst_rdata", {rd[1], rd[0]}, 64'd0);
    end else begin
      run_exp = (cyc >= WORDW + 1);
      chk("init_done", 64'(init_done), 64'(run_exp));
      chk("wr_ready", 64'(wr_ready), 64'(run_exp));
      if (cyc == 0) chk("pre_sweep_en", 64'({mea, wea}), 64'd0);
      if (cyc >= 1 && cyc <= WORDW) begin
        chk("sweep_en", 64'({mea, wea}), 64'd3);
        chk("sweep_adr", 64'(adra), 64'(cyc - 1));
        chk("sweep_da", 64'(da), 64'd0);
        chk("sweep_mask", 64'(wema), 64'({DATAW{1'b1}}));
      end
      if (run_exp) begin
        if (wr_valid && wr_ready) begin
          chk("wr_en", 64'({mea, wea}), 64'd3);
          chk("wr_adr", 64'(adra), 64'(wr_addr));
          chk("wr_da", 64'(da), 64'(wr_data));
          chk("wr_mask", 64'(wema), 64'(wr_mask));
          refm[wr_addr] = (refm[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end else begin
          chk("wr_idle_en", 64'(mea), 64'd0);
        end
      end
      for (int p = 0; p < 2; p++) begin
        pn = (p == 0) ? "rb" : "rc";
        pop = rv[p] && rr[p];
`ifdef PZTB_MEM_CTRL_BYPASS_EN
        stall = 1'b0;
`else
        stall = wr_valid && (ad[p] == wr_addr);
`endif
        exp_rdy = run_exp && !stall && ((expq[p].size() - int'(pop)) < 2);
        chk({pn, "_ready"}, 64'(rdy[p]), 64'(exp_rdy));
        if (hold[p]) begin
          chk({pn, "_hold_valid"}, 64'(rv[p]), 64'd1);
          chk({pn, "_hold_data"}, 64'(rd[p]), 64'(held[p]));
        end
        if (rv[p]) begin
          if (expq[p].size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL %s_spurious: rvalid=1 with no outstanding read at %0t", pn, $time);
          end else begin
            chk({pn, "_rdata"}, 64'(rd[p]), 64'(expq[p][0]));
            chk({pn, "_latency_ge2"}, 64'((cyc - fcq[p][0]) >= 2), 64'd1);
            if (pop) begin
              void'(expq[p].pop_front());
              void'(fcq[p].pop_front());
            end
          end
        end
        fire = v[p] && rdy[p];
        if (run_exp) chk({pn, "_me"}, 64'(me[p]), 64'(fire));
        if (fire) begin
          chk({pn, "_adr"}, 64'(madr[p]), 64'(ad[p]));
          expq[p].push_back(refm[ad[p]]);
          fcq[p].push_back(cyc);
        end
        hold[p] = rv[p] && !rr[p];
        held[p] = rd[p];
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    wr_valid = 1'b0; rb_valid = 1'b0; rc_valid = 1'b0;
  endtask

  task automatic rand_cycle();
    step();
    wr_valid  = 1'($urandom_range(0, 1));
    wr_addr   = ADDRW'($urandom_range(0, WORDW - 1));
    wr_data   = $urandom;
    wr_mask   = ($urandom_range(0, 1) == 1) ? {DATAW{1'b1}} : $urandom;
    rb_valid  = ($urandom_range(0, 9) < 6);
    rb_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDRW'($urandom_range(0, WORDW - 1));
    rc_valid  = ($urandom_range(0, 9) < 6);
    rc_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDRW'($urandom_range(0, WORDW - 1));
    rb_rready = ($urandom_range(0, 9) < 7);
    rc_rready = ($urandom_range(0, 9) < 7);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic got;
    idle_all();
    wr_addr = '0; wr_data = '0; wr_mask = '0; rb_addr = '0; rc_addr = '0;
    rb_rready = 1'b1; rc_rready = 1'b1;
    for (int i = 0; i < WORDW; i++) phys[i] = $urandom;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (WORDW + 4) step();

    // Write then read back on port B, check 2-cycle latency.
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; wr_mask = '1;
    step(); wr_valid = 1'b0; rb_valid = 1'b1; rb_addr = 4'd5;
    step(); rb_valid = 1'b0;
    @(negedge clk); chk("lat1_rvalid", 64'(rb_rvalid), 64'd0);
    step();
    @(negedge clk);
    chk("lat2_rvalid", 64'(rb_rvalid), 64'd1);
    chk("lat2_rdata", 64'(rb_rdata), 64'hDEADBEEF);

    // Back-to-back reads with no response drain.
    step(); rb_rready = 1'b0; rb_valid = 1'b1; rb_addr = 4'd1;
    step(); rb_addr = 4'd2;
    step(); rb_addr = 4'd5;
    @(negedge clk); chk("full_ready", 64'(rb_ready), 64'd0);
    step();
    step(); rb_rready = 1'b1;
    @(negedge clk); chk("pop_frees_ready", 64'(rb_ready), 64'd1);
    step(); rb_valid = 1'b0;
    repeat (4) step();

    // Masked write colliding with a port C read.
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'h12345678; wr_mask = '1;
    step(); wr_data = 32'h000000FF; wr_mask = 32'h0000FFFF; rc_valid = 1'b1; rc_addr = 4'd3;
`ifdef PZTB_MEM_CTRL_BYPASS_EN
    @(negedge clk); chk("coll_rc_ready", 64'(rc_ready), 64'd1);
`else
    @(negedge clk); chk("coll_rc_ready", 64'(rc_ready), 64'd0);
`endif
    step(); wr_valid = 1'b0;
    @(negedge clk); chk("post_coll_rc_ready", 64'(rc_ready), 64'd1);
    step(); rc_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rc_rvalid) got = 1'b1;
    end
    chk("coll_rc_seen", 64'(got), 64'd1);
    chk("coll_rc_rdata", 64'(rc_rdata), 64'h123400FF);

    repeat (600) rand_cycle();

    // Reset with one buffered and one in-flight response on port B.
    step(); idle_all(); rb_rready = 1'b1; rc_rready = 1'b1;
    repeat (6) step();
    rb_rready = 1'b0; rc_rready = 1'b0;
    rb_valid = 1'b1; rb_addr = 4'd7;
    step(); rb_addr = 4'd8;
    step(); rb_valid = 1'b0;
    #1 chk("pre_rst_rvalid", 64'(rb_rvalid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", 64'({rc_rvalid, rb_rvalid}), 64'd0);
    chk("async_rst_ready", 64'({wr_ready, rc_ready, rb_ready}), 64'd0);
    chk("async_rst_done", 64'(init_done), 64'd0);
    chk("async_rst_me", 64'({mea, meb, mec}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; rb_rready = 1'b1; rc_rready = 1'b1;
    repeat (WORDW + 4) step();

    repeat (300) rand_cycle();
    step(); idle_all(); rb_rready = 1'b1; rc_rready = 1'b1;
    repeat (6) step();
    for (int p = 0; p < 2; p++) chk("drained", 64'(expq[p].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
